// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
//
// MULT/MULTU/DIV/DIVU run for a fixed 33 cycles: 32 RUN iterations, then one
// FINISH cycle that writes HI/LO and pulses done. MTHI/MTLO write HI/LO in a
// single cycle. Requests arriving while busy are dropped.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   start    one-cycle request strobe
//   ALUCtrl  10001 MULT, 10010 MULTU, 10011 DIV, 10100 DIVU, 10101 MTHI, 10110 MTLO
//   a, b     rs / rt operands
//   busy     high while a MULT/DIV is in flight
//   done     one-cycle pulse when HI/LO receive a MULT/DIV result
//   hi, lo   HI and LO registers
`timescale 1ns/1ps
module muldiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITER  = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [4:0]       ALUCtrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned     CntW    = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(ITER - 1);

    localparam logic [4:0] OpMult  = 5'b10001;
    localparam logic [4:0] OpMultu = 5'b10010;
    localparam logic [4:0] OpDiv   = 5'b10011;
    localparam logic [4:0] OpDivu  = 5'b10100;
    localparam logic [4:0] OpMthi  = 5'b10101;
    localparam logic [4:0] OpMtlo  = 5'b10110;

    typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               res_neg_q, res_neg_d;   // product / quotient needs negating
    logic               rem_neg_q, rem_neg_d;   // remainder needs negating
    logic [WIDTH-1:0]   opnd_q, opnd_d;         // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc_q, acc_d;           // product; low half is multiplier/quotient
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    // Request decode and operand magnitudes
    logic             is_mul_op, is_div_op, is_signed_op;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign is_mul_op    = (ALUCtrl == OpMult) || (ALUCtrl == OpMultu);
    assign is_div_op    = (ALUCtrl == OpDiv) || (ALUCtrl == OpDivu);
    assign is_signed_op = (ALUCtrl == OpMult) || (ALUCtrl == OpDiv);
    assign a_neg        = is_signed_op & a[WIDTH-1];
    assign b_neg        = is_signed_op & b[WIDTH-1];
    assign mag_a        = a_neg ? -a : a;
    assign mag_b        = b_neg ? -b : b;

    // One shift-add multiply step
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});

    // One restoring-divide step on a 33-bit partial remainder
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_fits;
    assign div_shift = {rem_q, acc_q[WIDTH-1]};
    assign div_fits  = div_shift >= {1'b0, opnd_q};
    // Only taken when it fits, so the result is below the divisor and the low bits suffice.
    assign div_diff  = div_shift[WIDTH-1:0] - opnd_q;

    // Sign correction applied in FINISH
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;
    assign prod_fix = res_neg_q ? -acc_q : acc_q;
    assign quot_fix = res_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = rem_neg_q ? -rem_q : rem_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (is_mul_op) begin
                        is_div_d  = 1'b0;
                        opnd_d    = mag_a;
                        acc_d     = {{WIDTH{1'b0}}, mag_b};
                        rem_d     = '0;
                        res_neg_d = a_neg ^ b_neg;
                        rem_neg_d = 1'b0;
                        cnt_d     = '0;
                        state_d   = StRun;
                    end else if (is_div_op) begin
                        is_div_d  = 1'b1;
                        opnd_d    = mag_b;
                        acc_d     = {{WIDTH{1'b0}}, mag_a};
                        rem_d     = '0;
                        // With b==0 the divider yields all-ones / |a|; suppressing the
                        // quotient sign keeps lo=FFFF..F and the remainder sign restores a.
                        res_neg_d = (a_neg ^ b_neg) & (|b);
                        rem_neg_d = a_neg;
                        cnt_d     = '0;
                        state_d   = StRun;
                    end else if (ALUCtrl == OpMthi) begin
                        hi_d = a;
                    end else if (ALUCtrl == OpMtlo) begin
                        lo_d = a;
                    end
                end
            end
            StRun: begin
                cnt_d = cnt_q + 1'b1;
                if (is_div_q) begin
                    rem_d = div_fits ? div_diff : div_shift[WIDTH-1:0];
                    acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_fits};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                if (cnt_q == CntLast) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            opnd_q    <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            res_neg_q <= res_neg_d;
            rem_neg_q <= rem_neg_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
`timescale 1ns/1ps
module tb_muldiv_unit;

    localparam logic [4:0] OP_MULT  = 5'b10001;
    localparam logic [4:0] OP_MULTU = 5'b10010;
    localparam logic [4:0] OP_DIV   = 5'b10011;
    localparam logic [4:0] OP_DIVU  = 5'b10100;
    localparam logic [4:0] OP_MTHI  = 5'b10101;
    localparam logic [4:0] OP_MTLO  = 5'b10110;

    logic        clk, reset_n, start, busy, done;
    logic [4:0]  ALUCtrl;
    logic [31:0] a, b, hi, lo;

    int pass_cnt  = 0;
    int total_cnt = 0;

    muldiv_unit #(.WIDTH(32), .ITER(32)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .ALUCtrl(ALUCtrl),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, need completion");
        $fatal(1);
    end

    // Reference: {hi, lo} from plain 64-bit arithmetic
    function automatic logic [63:0] ref_result(input logic [4:0] op, input logic [31:0] x,
                                               input logic [31:0] y);
        longint      sx, sy, ux, uy;
        logic [63:0] r, q64, m64;
        sx = $signed(x);
        sy = $signed(y);
        ux = {32'd0, x};
        uy = {32'd0, y};
        r  = '0;
        case (op)
            OP_MULT:  r = sx * sy;
            OP_MULTU: r = ux * uy;
            OP_DIV, OP_DIVU: begin
                if (y == 32'd0) begin
                    r = {x, 32'hFFFFFFFF};
                end else begin
                    if (op == OP_DIV) begin
                        q64 = sx / sy;
                        m64 = sx % sy;
                    end else begin
                        q64 = ux / uy;
                        m64 = ux % uy;
                    end
                    r = {m64[31:0], q64[31:0]};
                end
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Issue one MULT/DIV request and follow it to done, sampling on negedges.
    task automatic run_op(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                          output int busy_cycles, output int done_pulses,
                          output bit timed_out, output bit held);
        logic [31:0] h0, l0;
        @(negedge clk);
        ALUCtrl = op; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0; ALUCtrl = 5'd0; a = $urandom; b = $urandom;
        h0 = hi; l0 = lo;
        busy_cycles = 0; done_pulses = 0; timed_out = 1'b1; held = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (busy) busy_cycles++;
            if (done) begin
                done_pulses++;
                timed_out = 1'b0;
                break;
            end
            if (hi !== h0 || lo !== l0) held = 1'b0;
            @(negedge clk);
        end
        @(negedge clk);
        if (done) done_pulses++;
        if (busy) busy_cycles++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; ALUCtrl = 5'd0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        total_cnt++; if (hi !== 32'd0) $display("FAIL reset_hi: got %h need 0", hi); else pass_cnt++;
        total_cnt++; if (lo !== 32'd0) $display("FAIL reset_lo: got %h need 0", lo); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b need 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b need 0", done); else pass_cnt++;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b need 0", busy); else pass_cnt++;
    endtask

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] x, y, eh, el;
    } vec_t;

    task automatic test_directed();
        vec_t vecs[10];
        int   bc, dp;
        bit   tmo, held;
        vecs[0] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[3] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4] = '{OP_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
        vecs[5] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[6] = '{OP_DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
        vecs[7] = '{OP_DIV,   32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
        vecs[8] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[9] = '{OP_DIV,   32'h80000000, 32'h00000000, 32'h80000000, 32'hFFFFFFFF};
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].x, vecs[i].y, bc, dp, tmo, held);
            total_cnt++; if (tmo) $display("FAIL dir%0d_timeout: got no done, need done", i); else pass_cnt++;
            total_cnt++; if (bc != 33) $display("FAIL dir%0d_busy_cycles: got %0d need 33", i, bc); else pass_cnt++;
            total_cnt++; if (dp != 1) $display("FAIL dir%0d_done_pulses: got %0d need 1", i, dp); else pass_cnt++;
            total_cnt++; if (!held) $display("FAIL dir%0d_hold: got hi/lo change during run, need hold", i); else pass_cnt++;
            total_cnt++; if (hi !== vecs[i].eh) $display("FAIL dir%0d_hi: got %h need %h", i, hi, vecs[i].eh); else pass_cnt++;
            total_cnt++; if (lo !== vecs[i].el) $display("FAIL dir%0d_lo: got %h need %h", i, lo, vecs[i].el); else pass_cnt++;
        end
    endtask

    task automatic test_mtxx();
        logic [31:0] h0, l0;
        @(negedge clk);
        ALUCtrl = OP_MTHI; a = 32'hDEADBEEF; start = 1'b1;
        l0 = lo;
        @(negedge clk);
        start = 1'b0;
        total_cnt++; if (hi !== 32'hDEADBEEF) $display("FAIL mthi_hi: got %h need deadbeef", hi); else pass_cnt++;
        total_cnt++; if (lo !== l0) $display("FAIL mthi_lo: got %h need %h", lo, l0); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL mthi_flags: got busy=%b done=%b need 0 0", busy, done); else pass_cnt++;
        ALUCtrl = OP_MTLO; a = 32'hCAFEF00D; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total_cnt++; if (lo !== 32'hCAFEF00D) $display("FAIL mtlo_lo: got %h need cafef00d", lo); else pass_cnt++;
        total_cnt++; if (hi !== 32'hDEADBEEF) $display("FAIL mtlo_hi: got %h need deadbeef", hi); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL mtlo_flags: got busy=%b done=%b need 0 0", busy, done); else pass_cnt++;
        // Unused codes are ignored
        h0 = hi; l0 = lo;
        ALUCtrl = 5'b10111; a = 32'h11111111; b = 32'h3; start = 1'b1;
        @(negedge clk);
        ALUCtrl = 5'b00000;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL badop_busy: got %b need 0", busy); else pass_cnt++;
        total_cnt++; if (hi !== h0 || lo !== l0) $display("FAIL badop_hilo: got %h/%h need %h/%h", hi, lo, h0, l0); else pass_cnt++;
    endtask

    task automatic test_busy_ignore();
        logic [31:0] h0, l0;
        int          bc;
        bit          seen, held;
        @(negedge clk);
        ALUCtrl = OP_MULT; a = 32'd3; b = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        h0 = hi; l0 = lo; bc = 0; seen = 1'b0; held = 1'b1;
        for (int i = 0; i < 64; i++) begin
            start = 1'b0;
            if (i == 5) begin
                ALUCtrl = OP_MTHI; a = 32'h12345678; start = 1'b1;
            end else if (i == 8) begin
                ALUCtrl = OP_MULT; a = 32'd7; b = 32'd7; start = 1'b1;
            end else if (i == 11) begin
                ALUCtrl = OP_MTLO; a = 32'h87654321; start = 1'b1;
            end
            if (busy) bc++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (hi !== h0 || lo !== l0) held = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        total_cnt++; if (!seen) $display("FAIL ign_timeout: got no done, need done"); else pass_cnt++;
        total_cnt++; if (bc != 33) $display("FAIL ign_busy_cycles: got %0d need 33", bc); else pass_cnt++;
        total_cnt++; if (!held) $display("FAIL ign_hold: got hi/lo change while busy, need hold"); else pass_cnt++;
        total_cnt++; if (hi !== 32'd0) $display("FAIL ign_hi: got %h need 0", hi); else pass_cnt++;
        total_cnt++; if (lo !== 32'd15) $display("FAIL ign_lo: got %h need f", lo); else pass_cnt++;
    endtask

    task automatic test_reset_midop();
        int bc, dp;
        bit tmo, held;
        @(negedge clk);
        ALUCtrl = OP_MULT; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        total_cnt++; if (busy !== 1'b1) $display("FAIL midrst_pre_busy: got %b need 1", busy); else pass_cnt++;
        reset_n = 1'b0;
        #1;
        total_cnt++; if (hi !== 32'd0 || lo !== 32'd0) $display("FAIL midrst_hilo: got %h/%h need 0/0", hi, lo); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL midrst_flags: got busy=%b done=%b need 0 0", busy, done); else pass_cnt++;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL midrst_after: got busy=%b done=%b need 0 0", busy, done); else pass_cnt++;
        run_op(OP_DIVU, 32'd100, 32'd7, bc, dp, tmo, held);
        total_cnt++; if (tmo || dp != 1) $display("FAIL midrst_divu_done: got pulses=%0d need 1", dp); else pass_cnt++;
        total_cnt++; if (lo !== 32'd14) $display("FAIL midrst_divu_lo: got %h need e", lo); else pass_cnt++;
        total_cnt++; if (hi !== 32'd2) $display("FAIL midrst_divu_hi: got %h need 2", hi); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [4:0]  op;
        logic [31:0] x, y;
        logic [63:0] exp;
        int          bc, dp, s;
        bit          tmo, held;
        for (int n = 0; n < 24; n++) begin
            op = OP_MULT + 5'($urandom_range(0, 3));
            x  = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 3))
                0:       y = 32'd0;
                1:       y = $urandom_range(1, 15);
                2:       y = $urandom;
                default: begin
                    s = $urandom_range(1, 9);
                    y = -s;
                end
            endcase
            exp = ref_result(op, x, y);
            run_op(op, x, y, bc, dp, tmo, held);
            total_cnt++; if (tmo || dp != 1 || bc != 33) $display("FAIL rnd%0d_timing: got busy=%0d pulses=%0d need 33 1", n, bc, dp); else pass_cnt++;
            total_cnt++; if (hi !== exp[63:32]) $display("FAIL rnd%0d_hi op=%b a=%h b=%h: got %h need %h", n, op, x, y, hi, exp[63:32]); else pass_cnt++;
            total_cnt++; if (lo !== exp[31:0]) $display("FAIL rnd%0d_lo op=%b a=%h b=%h: got %h need %h", n, op, x, y, lo, exp[31:0]); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mtxx();
        test_busy_ignore();
        test_reset_midop();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
